real_param_sweep_ctrl: RTL and testbench

Sequencer that walks a two-level parameter grid, outer index `m`, inner index `r`, and issues one fixed-point request per grid point. Each request value is `m + r + 0.5` and goes to a downstream parameterised consumer. The block then checks the consumer's returned value against the issued one. It counts passes and mismatches and signals completion. It sits between a test/config master and the instance under sweep, and is the synthesizable, clocked counterpart of the generate-time parameter check.

---
 rtl/real_param_sweep_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_real_param_sweep_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/real_param_sweep_ctrl.sv
// real_param_sweep_ctrl
//   Walks a two-level parameter grid (outer m, inner r). For each grid point it
//   issues one fixed-point request of value m + r + 0.5. It then compares the
//   consumer's echoed value with the issued one and counts matches and
//   mismatches.
//
// Ports
//   clk        in   single clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   begin a sweep (honoured only while idle)
//   req_valid  out  request valid
//   req_ready  in   consumer accepts request
//   req_value  out  ((m+r)<<FRAC_W) + (1<<(FRAC_W-1)), truncated to W
//   req_m      out  current outer index
//   req_r      out  current inner index
//   rsp_valid  in   consumer response strobe
//   rsp_value  in   consumer's echoed value
//   busy       out  high whenever a sweep is in progress
//   done       out  one-cycle pulse at end of sweep
//   err        out  sticky mismatch flag for this sweep
//   pass_cnt   out  matching responses (saturating)
//   err_cnt    out  mismatching responses (saturating)
module real_param_sweep_ctrl #(
  parameter int M_START = 10,
  parameter int M_STEP  = 10,
  parameter int M_END   = 20,
  parameter int R_END   = 1,
  parameter int FRAC_W  = 4,
  parameter int W       = 16,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             req_valid,
  input  logic             req_ready,
  output logic [W-1:0]     req_value,
  output logic [7:0]       req_m,
  output logic [7:0]       req_r,
  input  logic             rsp_valid,
  input  logic [W-1:0]     rsp_value,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // The 0.5 offset in fixed point; shifting within W bits is the same as
  // truncating the full-width result.
  localparam logic [W-1:0] HALF = W'(1) << (FRAC_W - 1);

  state_t           state_r;
  state_t           state_s;
  logic [7:0]       m_r;
  logic [7:0]       r_r;
  logic [CNT_W-1:0] pass_cnt_r;
  logic [CNT_W-1:0] err_cnt_r;
  logic             err_r;
  logic [8:0]       sum_s;
  logic             r_more_s;
  logic             m_more_s;
  logic             rsp_hit_s;
  logic             match_s;

  // Saturating increment: the counter sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      sat_inc = v;
    end else begin
      sat_inc = v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  assign sum_s     = 9'(m_r) + 9'(r_r);
  assign req_value = (W'(sum_s) << FRAC_W) + HALF;
  assign req_m     = m_r;
  assign req_r     = r_r;
  assign r_more_s  = (r_r < 8'(R_END));
  assign m_more_s  = (m_r < 8'(M_END));
  assign rsp_hit_s = (state_r == WAIT) && rsp_valid;
  assign match_s   = (rsp_value == req_value);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; the last grid point leads to DONE instead of ISSUE.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = ISSUE;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        if (req_ready) begin
          state_s = WAIT;
        end else begin
          state_s = ISSUE;
        end
      end
      WAIT: begin
        if (rsp_valid) begin
          if (r_more_s || m_more_s) begin
            state_s = ISSUE;
          end else begin
            state_s = DONE;
          end
        end else begin
          state_s = WAIT;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Output decode from the registered state.
  always_comb begin
    req_valid = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state_r)
      IDLE:    busy      = 1'b0;
      ISSUE:   req_valid = 1'b1;
      WAIT:    req_valid = 1'b0;
      DONE:    done      = 1'b1;
      default: busy      = 1'b0;
    endcase
  end

  // Grid indices: load on start, advance r then m on each accepted response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_r <= 8'(M_START);
      r_r <= 8'd0;
    end else if ((state_r == IDLE) && start) begin
      m_r <= 8'(M_START);
      r_r <= 8'd0;
    end else if (rsp_hit_s) begin
      if (r_more_s) begin
        r_r <= r_r + 8'd1;
      end else if (m_more_s) begin
        r_r <= 8'd0;
        m_r <= m_r + 8'(M_STEP);
      end else begin
        r_r <= r_r;
      end
    end else begin
      m_r <= m_r;
    end
  end

  // Scoreboard counters and sticky error; they hold after DONE until start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_cnt_r <= {CNT_W{1'b0}};
      err_cnt_r  <= {CNT_W{1'b0}};
      err_r      <= 1'b0;
    end else if ((state_r == IDLE) && start) begin
      pass_cnt_r <= {CNT_W{1'b0}};
      err_cnt_r  <= {CNT_W{1'b0}};
      err_r      <= 1'b0;
    end else if (rsp_hit_s) begin
      if (match_s) begin
        pass_cnt_r <= sat_inc(pass_cnt_r);
      end else begin
        err_cnt_r <= sat_inc(err_cnt_r);
        err_r     <= 1'b1;
      end
    end else begin
      err_r <= err_r;
    end
  end

  assign pass_cnt = pass_cnt_r;
  assign err_cnt  = err_cnt_r;
  assign err      = err_r;

endmodule

// File: tb/tb_real_param_sweep_ctrl.sv
// tb_real_param_sweep_ctrl
//   Directed sweeps with randomized response latency and stall placement. A
//   default-parameter instance (u_dut) and a CNT_W=2/R_END=3 instance (u_sat)
//   share the consumer-side inputs. The expected request list is built from
//   the grid rule value = (m + r + 0.5) * 2^FRAC_W. The expected counts come
//   from simple pass/error tallies clipped to the counter maximum.
module tb_real_param_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start1, start2, req_ready, rsp_valid;
  logic [15:0] rsp_value;
  logic        sel;

  logic        rv1, busy1, done1, err1;
  logic [15:0] val1;
  logic [7:0]  m1, r1, pc1, ec1;
  logic        rv2, busy2, done2, err2;
  logic [15:0] val2;
  logic [7:0]  m2, r2;
  logic [1:0]  pc2, ec2;

  int n_checks = 0;
  int n_err    = 0;
  int last_pass = 0, last_errc = 0, last_errf = 0;

  always #5 clk = ~clk;

  real_param_sweep_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .start(start1), .req_valid(rv1), .req_ready(req_ready),
    .req_value(val1), .req_m(m1), .req_r(r1), .rsp_valid(rsp_valid), .rsp_value(rsp_value),
    .busy(busy1), .done(done1), .err(err1), .pass_cnt(pc1), .err_cnt(ec1)
  );

  real_param_sweep_ctrl #(.R_END(3), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start2), .req_valid(rv2), .req_ready(req_ready),
    .req_value(val2), .req_m(m2), .req_r(r2), .rsp_valid(rsp_valid), .rsp_value(rsp_value),
    .busy(busy2), .done(done2), .err(err2), .pass_cnt(pc2), .err_cnt(ec2)
  );

  wire        c_rv   = sel ? rv2   : rv1;
  wire [15:0] c_val  = sel ? val2  : val1;
  wire [7:0]  c_m    = sel ? m2    : m1;
  wire [7:0]  c_r    = sel ? r2    : r1;
  wire        c_busy = sel ? busy2 : busy1;
  wire        c_done = sel ? done2 : done1;
  wire        c_err  = sel ? err2  : err1;
  wire [7:0]  c_pc   = sel ? {6'd0, pc2} : pc1;
  wire [7:0]  c_ec   = sel ? {6'd0, ec2} : ec1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int smin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic drive_start(input logic v);
    if (sel) start2 = v;
    else     start1 = v;
  endtask

  // One sweep on the selected instance. stall_pt/bad_pt/abort_pt of -1 disable
  // the corresponding feature.
  task automatic run_sweep(input logic sel_i, input int stall_pt, input int stall_n,
                           input int bad_pt, input bit spur, input int lat_max,
                           input int abort_pt, input bit chk_time);
    int rend, cmax, npts, edges, pass, nerr, lat;
    logic [15:0] qv[$];
    int qm[$], qr[$];
    sel  = sel_i;
    rend = sel_i ? 3 : 1;
    cmax = sel_i ? 3 : 255;
    for (int m = 10; m <= 20; m += 10) begin
      for (int r = 0; r <= rend; r++) begin
        qm.push_back(m);
        qr.push_back(r);
        qv.push_back(16'((m + r) * 16 + 8));
      end
    end
    npts = qv.size();

    if (spur) begin
      // A response strobe while idle must not touch the held results.
      rsp_valid = 1'b1;
      rsp_value = 16'h1234;
      tick();
      rsp_valid = 1'b0;
      chk("idle_spur_busy", 32'(c_busy), 32'd0);
      chk("idle_spur_pass", 32'(c_pc), 32'(last_pass));
      chk("idle_spur_errc", 32'(c_ec), 32'(last_errc));
      chk("idle_spur_errf", 32'(c_err), 32'(last_errf));
    end

    drive_start(1'b1);
    tick();
    drive_start(1'b0);
    edges = 0;
    chk("start_rv", 32'(c_rv), 32'd1);
    chk("start_busy", 32'(c_busy), 32'd1);
    chk("start_clr_pass", 32'(c_pc), 32'd0);
    chk("start_clr_errf", 32'(c_err), 32'd0);
    pass = 0;
    nerr = 0;

    for (int p = 0; p < npts; p++) begin
      if (p == stall_pt) begin
        repeat (stall_n) begin
          req_ready = 1'b0;
          tick();
          edges++;
          chk("stall_rv", 32'(c_rv), 32'd1);
          chk("stall_value", 32'(c_val), 32'(qv[p]));
        end
      end
      if (spur && p == 1) begin
        // Strobe and start during ISSUE are both to be ignored.
        req_ready = 1'b0;
        rsp_valid = 1'b1;
        rsp_value = qv[p];
        drive_start(1'b1);
        tick();
        edges++;
        rsp_valid = 1'b0;
        drive_start(1'b0);
        chk("issue_spur_rv", 32'(c_rv), 32'd1);
        chk("issue_spur_m", 32'(c_m), 32'(qm[p]));
        chk("issue_spur_r", 32'(c_r), 32'(qr[p]));
        chk("issue_spur_pass", 32'(c_pc), 32'(smin(pass, cmax)));
      end
      chk("req_rv", 32'(c_rv), 32'd1);
      chk("req_value", 32'(c_val), 32'(qv[p]));
      chk("req_m", 32'(c_m), 32'(qm[p]));
      chk("req_r", 32'(c_r), 32'(qr[p]));
      req_ready = 1'b1;
      tick();
      edges++;
      req_ready = 1'b0;
      chk("wait_rv", 32'(c_rv), 32'd0);
      chk("wait_busy", 32'(c_busy), 32'd1);

      if (p == abort_pt) begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_rv", 32'(c_rv), 32'd0);
        chk("rst_busy", 32'(c_busy), 32'd0);
        chk("rst_done", 32'(c_done), 32'd0);
        chk("rst_err", 32'(c_err), 32'd0);
        chk("rst_pass", 32'(c_pc), 32'd0);
        chk("rst_errc", 32'(c_ec), 32'd0);
        tick();
        tick();
        chk("rst_no_done", 32'(c_done), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("rst_rel_done", 32'(c_done), 32'd0);
        chk("rst_rel_m", 32'(c_m), 32'd10);
        last_pass = 0;
        last_errc = 0;
        last_errf = 0;
        return;
      end

      lat = $urandom_range(lat_max, 0);
      repeat (lat) begin
        tick();
        edges++;
        chk("lat_rv", 32'(c_rv), 32'd0);
      end
      rsp_valid = 1'b1;
      rsp_value = (p == bad_pt) ? (qv[p] ^ 16'h0008) : qv[p];
      tick();
      edges++;
      rsp_valid = 1'b0;
      if (p == bad_pt) nerr++;
      else             pass++;
      chk("pass_cnt", 32'(c_pc), 32'(smin(pass, cmax)));
      chk("err_cnt", 32'(c_ec), 32'(smin(nerr, cmax)));
      chk("err_flag", 32'(c_err), 32'(nerr > 0));
      chk("done_edge", 32'(c_done), 32'(p == npts - 1));
    end

    // With no stalls and 1-cycle echo, each point costs two edges, and DONE is
    // the cycle right after that.
    if (chk_time) chk("done_latency", 32'(edges), 32'(2 * npts));
    tick();
    chk("done_pulse_end", 32'(c_done), 32'd0);
    chk("end_busy", 32'(c_busy), 32'd0);
    chk("hold_pass", 32'(c_pc), 32'(smin(pass, cmax)));
    chk("hold_errf", 32'(c_err), 32'(nerr > 0));
    last_pass = smin(pass, cmax);
    last_errc = smin(nerr, cmax);
    last_errf = (nerr > 0) ? 1 : 0;
  endtask

  initial begin
    rst_n     = 1'b0;
    start1    = 1'b0;
    start2    = 1'b0;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_value = 16'd0;
    sel       = 1'b0;
    tick();
    chk("in_rst_rv", 32'(rv1), 32'd0);
    chk("in_rst_busy", 32'(busy1), 32'd0);
    chk("in_rst_done", 32'(done1), 32'd0);
    chk("in_rst_pass", 32'(pc1), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_m", 32'(m1), 32'd10);
    chk("post_rst_r", 32'(r1), 32'd0);
    chk("post_rst_err", 32'(err1), 32'd0);
    chk("post_rst_errc", 32'(ec1), 32'd0);

    run_sweep(1'b0, -1, 0, -1, 1'b0, 0, -1, 1'b1);
    run_sweep(1'b0, 1, 3, -1, 1'b0, 0, -1, 1'b0);
    run_sweep(1'b0, -1, 0, 1, 1'b0, 0, -1, 1'b0);
    run_sweep(1'b0, -1, 0, -1, 1'b1, 2, -1, 1'b0);
    run_sweep(1'b0, -1, 0, 0, 1'b0, 0, 2, 1'b0);
    run_sweep(1'b0, -1, 0, -1, 1'b0, 0, -1, 1'b1);
    run_sweep(1'b0, int'($urandom_range(3, 0)), int'($urandom_range(4, 1)),
              int'($urandom_range(3, 0)), 1'b0, 3, -1, 1'b0);
    run_sweep(1'b1, -1, 0, -1, 1'b0, 0, -1, 1'b1);
    run_sweep(1'b1, int'($urandom_range(7, 0)), 2, int'($urandom_range(7, 0)),
              1'b1, 2, -1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
